// File: rtl/tinyalu_if.sv
// Command/response bundle between a tinyalu initiator (BFM) and the responder.
interface tinyalu_if #(
  parameter int unsigned DATA_W = 8
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_W-1:0]     A;
  logic [DATA_W-1:0]     B;
  logic                  done;
  logic [2*DATA_W-1:0]   result;
  logic                  busy;
  logic                  err;

  modport master (output start, op, A, B, input done, result, busy, err);
  modport slave  (input start, op, A, B, output done, result, busy, err);
endinterface

// File: rtl/tinyalu_responder.sv
// tinyalu responder: accepts a start/done command, executes add/and/xor in one
// cycle or mul by iterative shift-add, and returns the result with a done pulse.
module tinyalu_responder #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MUL_ITER = DATA_W
) (
  input  logic     clk,
  input  logic     reset_n,
  tinyalu_if.slave bus
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  logic [2:0]        state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [DATA_W-1:0] a_q,      a_d;
  logic [DATA_W-1:0] b_q,      b_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [RES_W-1:0]  acc_q,    acc_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              done_q,   done_d;
  logic              busy_q,   busy_d;
  logic              err_q,    err_d;
  logic [RES_W-1:0]  mul_sum;

  // State, latched command and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output logic; done is raised one cycle after DONE is entered
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    mul_sum  = acc_q + (b_q[cnt_q] ? (RES_W'(a_q) << cnt_q) : RES_W'(0));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.A;
          b_d     = bus.B;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (bus.op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        if (!bus.start) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          case (op_q)
            OP_NOP:  result_d = result_q;
            OP_ADD:  result_d = RES_W'(a_q) + RES_W'(b_q);
            OP_AND:  result_d = RES_W'(a_q & b_q);
            OP_XOR:  result_d = RES_W'(a_q ^ b_q);
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
          state_d = DONE;
        end
      end
      MUL: begin
        if (!bus.start) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = mul_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = mul_sum;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // A still-asserted start is the old command; wait for it to drop
        if (!bus.start) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// Self-checking bench for tinyalu_responder: directed and random commands
// against an arithmetic reference model, plus abort and async-reset cases.
module tb_tinyalu_responder;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [15:0] exp_prev;

  tinyalu_if #(.DATA_W(8)) bus ();

  tinyalu_responder #(.DATA_W(8), .MUL_ITER(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [7:0] a,
                                             input logic [7:0] b, input logic [15:0] prev);
    case (o)
      3'd0:    return prev;
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a ^ b);
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Issue one command, scramble inputs after accept, check latency/result, then release
  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input int extra_hold);
    logic [15:0] er;
    logic        ee;
    bit          seen;
    int          lat;
    er   = ref_result(o, a, b, exp_prev);
    ee   = (o > 3'd4);
    seen = 0;
    lat  = -1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        bus.op = 3'($urandom);
        bus.A  = 8'($urandom);
        bus.B  = 8'($urandom);
      end
      if (bus.done) begin
        seen = 1;
        lat  = i;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), (o == 3'd4) ? 32'd9 : 32'd2);
    check("result", 32'(bus.result), 32'(er));
    check("err", 32'(bus.err), 32'(ee));
    exp_prev = er;
    for (int i = 0; i <= extra_hold; i++) begin
      @(negedge clk);
      check("done_single_pulse", 32'(bus.done), 32'd0);
      check("busy_in_hold", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_released", 32'(bus.busy), 32'd0);
    check("result_holds", 32'(bus.result), 32'(er));
  endtask

  initial begin
    bit any_done;
    checks    = 0;
    errors    = 0;
    exp_prev  = 16'h0000;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    send(3'd1, 8'hFF, 8'h01, 0);
    send(3'd4, 8'hFF, 8'hFF, 0);
    send(3'd4, 8'h00, 8'h55, 1);
    send(3'd2, 8'hF0, 8'h3C, 3);
    send(3'd3, 8'hF0, 8'h3C, 0);
    send(3'd6, 8'h01, 8'h01, 0);
    send(3'd0, 8'h12, 8'h34, 0);
    send(3'd1, 8'h12, 8'h34, 0);

    // Abort a mul mid-flight: no done, result unchanged
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.A     = 8'd3;
    bus.B     = 8'd5;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 32'(bus.busy), 32'd0);
    any_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) any_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(any_done), 32'd0);
    check("abort_result_kept", 32'(bus.result), 32'(exp_prev));

    send(3'd1, 8'd2, 8'd3, 0);

    for (int n = 0; n < 24; n++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a multiply
    send(3'd1, 8'h40, 8'h07, 0);
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.A     = 8'hA5;
    bus.B     = 8'h3C;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_result", 32'(bus.result), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_err", 32'(bus.err), 32'd0);
    exp_prev = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    send(3'd1, 8'h80, 8'h90, 0);
    send(3'd4, 8'h0D, 8'hF3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
